// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target for the MIPS load/store port.
// It accepts one word request, waits WAIT_CYCLES cycles, then commits the
// store or fetches the load word. The result is held under a valid/ready
// handshake. Only one request is outstanding at a time, so a load that
// follows a store to the same word always sees the stored data.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_LIM  = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] mem [DEPTH_WORDS];

    // Commit-side signals. These select between the incoming request and
    // the latched one, depending on which edge enters RESP.
    logic             accept;
    logic             commit;
    logic             c_we;
    logic [31:0]      c_addr;
    logic [31:0]      c_wdata;
    logic             c_err;
    logic [IDX_W-1:0] c_idx;
    logic             mem_we;

    // Ready is open in IDLE. In RESP it follows resp_ready, so the requester
    // can issue its next request in the same cycle it takes a response.
    always_comb begin
        req_ready = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
    end

    // Next-state, request latching and commit/response computation
    always_comb begin
        // NOTE: every variable gets a default here, so no path can leave it unassigned and infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        commit       = 1'b0;
        c_we         = we_q;
        c_addr       = addr_q;
        c_wdata      = wdata_q;

        accept = req_valid && req_ready;

        if (accept) begin
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            cnt_d   = WAIT_INIT;
            if (WAIT_CYCLES == 0) begin
                // Zero wait: commit on the accepting edge, using the live request
                state_d = RESP;
                commit  = 1'b1;
                c_we    = req_we;
                c_addr  = req_addr;
                c_wdata = req_wdata;
            end else begin
                state_d      = BUSY;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
            end
        end else begin
            case (state_q)
                BUSY: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                        cnt_d   = 4'd0;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_d      = IDLE;
                        resp_valid_d = 1'b0;
                        resp_err_d   = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // Upper address bits only take part in the range check
        c_err  = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= DEPTH_LIM);
        c_idx  = c_addr[IDX_W+1:2];
        mem_we = commit && c_we && !c_err;

        if (commit) begin
            resp_valid_d = 1'b1;
            resp_err_d   = c_err;
            resp_rdata_d = (c_we || c_err) ? 32'd0 : mem[c_idx];
        end
    end

    // Control and response registers. The async reset drops any pending
    // request; a store that has not reached RESP is never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments, so every flop samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Word RAM write port; a store commits on the edge that enters RESP
    always_ff @(posedge clk) begin
        // NOTE: the RAM has no reset, so it can map onto plain on-chip memory.
        if (mem_we) begin
            mem[c_idx] <= c_wdata;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder.
// Instance dut runs with WAIT_CYCLES=2 and instance dut0 with WAIT_CYCLES=0.
// Both share the clock and reset.
module tb_dmem_responder;

    logic        clk;
    logic        reset;

    logic        req_valid, req_we, req_ready, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;

    logic        r0_valid, r0_we, r0_ready, p0_valid, p0_ready, p0_err;
    logic [31:0] r0_addr, r0_wdata, p0_rdata;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (r0_valid),
        .req_we     (r0_we),
        .req_addr   (r0_addr),
        .req_wdata  (r0_wdata),
        .req_ready  (r0_ready),
        .resp_valid (p0_valid),
        .resp_ready (p0_ready),
        .resp_rdata (p0_rdata),
        .resp_err   (p0_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete request on dut with resp_ready=1. Accept happens at edge E0.
    // The response is valid after E2 and the handshake completes at E3.
    task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_err);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        check({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        check({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
        check({tag, ".busy_valid0"}, 32'(resp_valid), 32'd0);
        step();
        check({tag, ".busy_valid1"}, 32'(resp_valid), 32'd0);
        step();
        check({tag, ".valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
        check({tag, ".err"}, 32'(resp_err), 32'(exp_err));
        step();
        check({tag, ".idle_valid"}, 32'(resp_valid), 32'd0);
        check({tag, ".idle_err"}, 32'(resp_err), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;
        r0_valid   = 1'b0;
        r0_we      = 1'b0;
        r0_addr    = 32'd0;
        r0_wdata   = 32'd0;
        p0_ready   = 1'b1;

        // Reset state
        #2;
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.resp_err", 32'(resp_err), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // 1: store then load of the same word; latency WAIT_CYCLES+1
        run_req("t1.st", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0);
        run_req("t1.ld", 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);

        // 2: misaligned and out-of-range requests, plus the last valid word
        run_req("t2.ld13", 1'b0, 32'h0000_0013, 32'd0, 32'd0, 1'b1);
        run_req("t2.st102", 1'b1, 32'h0000_0102, 32'h5555_AAAA, 32'd0, 1'b1);
        run_req("t2.ld100", 1'b0, 32'h0000_0100, 32'd0, 32'd0, 1'b1);
        run_req("t2.st12", 1'b1, 32'h0000_0012, 32'h0BAD_0BAD, 32'd0, 1'b1);
        run_req("t2.ld10", 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
        run_req("t2.stfc", 1'b1, 32'h0000_00FC, 32'hA5A5_5A5A, 32'd0, 1'b0);
        run_req("t2.ldfc", 1'b0, 32'h0000_00FC, 32'd0, 32'hA5A5_5A5A, 1'b0);
        run_req("t2.ldhi", 1'b0, 32'h8000_0010, 32'd0, 32'd0, 1'b1);

        // 3: backpressure holds the response for 5 cycles
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h0000_00FC;
        step();
        req_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check("t3.hold_valid", 32'(resp_valid), 32'd1);
            check("t3.hold_rdata", resp_rdata, 32'hA5A5_5A5A);
            check("t3.hold_ready", 32'(req_ready), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        check("t3.release_ready", 32'(req_ready), 32'd1);
        step();
        check("t3.done_valid", 32'(resp_valid), 32'd0);
        check("t3.done_ready", 32'(req_ready), 32'd1);

        // 6: address changes while BUSY are ignored
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0010;
        step();
        req_addr  = 32'h0000_00FC;
        step();
        req_addr  = 32'h0000_0013;
        step();
        req_valid = 1'b0;
        check("t6.valid", 32'(resp_valid), 32'd1);
        check("t6.rdata", resp_rdata, 32'hDEAD_BEEF);
        check("t6.err", 32'(resp_err), 32'd0);
        step();
        check("t6.idle", 32'(resp_valid), 32'd0);

        // 4a: back-to-back on WAIT_CYCLES=2, store then load of the same word
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0014;
        req_wdata = 32'h1357_9BDF;
        step();
        req_we = 1'b0;
        step();
        step();
        check("t4a.st_valid", 32'(resp_valid), 32'd1);
        check("t4a.st_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        check("t4a.b2b_valid", 32'(resp_valid), 32'd0);
        check("t4a.b2b_ready", 32'(req_ready), 32'd0);
        step();
        step();
        check("t4a.ld_valid", 32'(resp_valid), 32'd1);
        check("t4a.ld_rdata", resp_rdata, 32'h1357_9BDF);
        step();
        check("t4a.idle", 32'(resp_valid), 32'd0);

        // 4b: WAIT_CYCLES=0 gives one response per cycle
        r0_valid = 1'b1;
        r0_we    = 1'b1;
        r0_addr  = 32'h0000_0000;
        r0_wdata = 32'h1111_1111;
        step();
        check("t4b.st0_valid", 32'(p0_valid), 32'd1);
        check("t4b.st0_rdata", p0_rdata, 32'd0);
        r0_addr  = 32'h0000_0004;
        r0_wdata = 32'h2222_2222;
        step();
        check("t4b.st4_valid", 32'(p0_valid), 32'd1);
        check("t4b.st4_err", 32'(p0_err), 32'd0);
        r0_we   = 1'b0;
        r0_addr = 32'h0000_0000;
        step();
        check("t4b.ld0_valid", 32'(p0_valid), 32'd1);
        check("t4b.ld0_rdata", p0_rdata, 32'h1111_1111);
        r0_addr = 32'h0000_0004;
        step();
        check("t4b.ld4_rdata", p0_rdata, 32'h2222_2222);
        r0_addr = 32'h0000_0003;
        step();
        check("t4b.mis_err", 32'(p0_err), 32'd1);
        check("t4b.mis_rdata", p0_rdata, 32'd0);
        r0_valid = 1'b0;
        step();
        check("t4b.idle_valid", 32'(p0_valid), 32'd0);
        check("t4b.idle_err", 32'(p0_err), 32'd0);

        // 5: reset during BUSY discards the store
        run_req("t5.pre_st", 1'b1, 32'h0000_0020, 32'h0BAD_CAFE, 32'd0, 1'b0);
        run_req("t5.pre_ld", 1'b0, 32'h0000_0020, 32'd0, 32'h0BAD_CAFE, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'h1234_5678;
        step();
        req_valid = 1'b0;
        check("t5.busy_ready", 32'(req_ready), 32'd0);
        check("t5.busy_rdata_kept", resp_rdata, 32'h0BAD_CAFE);
        #2;
        reset = 1'b1;
        #1;
        check("t5.rst_ready", 32'(req_ready), 32'd1);
        check("t5.rst_valid", 32'(resp_valid), 32'd0);
        check("t5.rst_rdata", resp_rdata, 32'd0);
        check("t5.rst_err", 32'(resp_err), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        run_req("t5.post_ld", 1'b0, 32'h0000_0020, 32'd0, 32'h0BAD_CAFE, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
